// File: rtl/decode_pkg.sv
// Shared decode types: ALU op encoding, opcodes and the
// decoded-instruction bundle passed from decode to execute.
package decode_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_PASSB,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
        ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
        ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
    } alu_op_t;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_valid;
        logic       rs2_valid;
        logic       wr_en;
        logic [2:0] funct3;
        alu_op_t    alu_op;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_load;
        logic       is_store;
        logic       is_lui;
        logic       is_auipc;
        logic       illegal;
    } dec_t;

    // funct3 -> base integer op (bit 30 handled by the caller)
    function automatic alu_op_t base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // funct3 -> M-extension op; enum order follows funct3
    function automatic alu_op_t m_op(input logic [2:0] f3);
        return alu_op_t'(ALU_MUL + {2'b00, f3});
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32/RV64 instruction decoder: fields,
// immediate, class flags, ALU op and illegal detection.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]     instr,
    output dec_t            dec,
    output logic [XLEN-1:0] imm
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]      opc;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            rd_v;
    logic            ill;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0}));

    // Opcode-directed decode; illegal encodings collapse to a safe NOP-like bundle
    always_comb begin
        dec        = '0;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.funct3 = f3;
        dec.alu_op = ALU_ADD;
        imm        = '0;
        rd_v       = 1'b0;
        ill        = 1'b0;
        unique case (1'b1)
            (opc == OP): begin
                rd_v = 1'b1;
                dec.rs1_valid = 1'b1;
                dec.rs2_valid = 1'b1;
                if (f7 == 7'h00)
                    dec.alu_op = base_op(f3);
                else if (f7 == 7'h20 && f3 == 3'd0)
                    dec.alu_op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5)
                    dec.alu_op = ALU_SRA;
                else if (f7 == 7'h01 && ENABLE_M)
                    dec.alu_op = m_op(f3);
                else
                    ill = 1'b1;
            end
            (opc == OP_IMM): begin
                rd_v = 1'b1;
                dec.rs1_valid = 1'b1;
                imm = imm_i;
                if (f3 == 3'd1) begin
                    dec.alu_op = ALU_SLL;
                    ill = (instr[31:26] != 6'd0) || (!RV64 && instr[25]);
                end else if (f3 == 3'd5) begin
                    dec.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
                    ill = ({instr[31], instr[29:26]} != 5'd0)
                        || (!RV64 && instr[25]);
                end else begin
                    dec.alu_op = base_op(f3);
                end
            end
            (opc == LOAD): begin
                rd_v = 1'b1;
                dec.rs1_valid = 1'b1;
                dec.is_load = 1'b1;
                imm = imm_i;
                ill = !((f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                    || (RV64 && (f3 == 3'd3 || f3 == 3'd6)));
            end
            (opc == STORE): begin
                dec.rs1_valid = 1'b1;
                dec.rs2_valid = 1'b1;
                dec.is_store = 1'b1;
                imm = imm_s;
                ill = f3[2] || (f3 == 3'd3 && !RV64);
            end
            (opc == BRANCH): begin
                dec.rs1_valid = 1'b1;
                dec.rs2_valid = 1'b1;
                dec.is_branch = 1'b1;
                dec.alu_op = ALU_SUB;
                imm = imm_b;
                ill = (f3[2:1] == 2'b01);
            end
            (opc == JAL): begin
                rd_v = 1'b1;
                dec.is_jal = 1'b1;
                imm = imm_j;
            end
            (opc == JALR): begin
                rd_v = 1'b1;
                dec.rs1_valid = 1'b1;
                dec.is_jalr = 1'b1;
                imm = imm_i;
                ill = (f3 != 3'd0);
            end
            (opc == LUI): begin
                rd_v = 1'b1;
                dec.is_lui = 1'b1;
                dec.alu_op = ALU_PASSB;
                imm = imm_u;
            end
            (opc == AUIPC): begin
                rd_v = 1'b1;
                dec.is_auipc = 1'b1;
                imm = imm_u;
            end
            (RV64 && opc == OP_32): begin
                rd_v = 1'b1;
                dec.rs1_valid = 1'b1;
                dec.rs2_valid = 1'b1;
                if (f7 == 7'h00 && f3 == 3'd0)
                    dec.alu_op = ALU_ADDW;
                else if (f7 == 7'h00 && f3 == 3'd1)
                    dec.alu_op = ALU_SLLW;
                else if (f7 == 7'h00 && f3 == 3'd5)
                    dec.alu_op = ALU_SRLW;
                else if (f7 == 7'h20 && f3 == 3'd0)
                    dec.alu_op = ALU_SUBW;
                else if (f7 == 7'h20 && f3 == 3'd5)
                    dec.alu_op = ALU_SRAW;
                else if (f7 == 7'h01 && ENABLE_M && f3 == 3'd0)
                    dec.alu_op = ALU_MULW;
                else if (f7 == 7'h01 && ENABLE_M && f3[2])
                    dec.alu_op = alu_op_t'(ALU_DIVW + {3'b000, f3[1:0]});
                else
                    ill = 1'b1;
            end
            (RV64 && opc == OP_IMM_32): begin
                rd_v = 1'b1;
                dec.rs1_valid = 1'b1;
                imm = imm_i;
                if (f3 == 3'd0)
                    dec.alu_op = ALU_ADDW;
                else if (f3 == 3'd1 && f7 == 7'h00)
                    dec.alu_op = ALU_SLLW;
                else if (f3 == 3'd5 && f7 == 7'h00)
                    dec.alu_op = ALU_SRLW;
                else if (f3 == 3'd5 && f7 == 7'h20)
                    dec.alu_op = ALU_SRAW;
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            rd_v = 1'b0;
            imm = '0;
            dec.alu_op = ALU_ADD;
            dec.rs1_valid = 1'b0;
            dec.rs2_valid = 1'b0;
            {dec.is_branch, dec.is_jal, dec.is_jalr, dec.is_load,
             dec.is_store, dec.is_lui, dec.is_auipc} = '0;
        end
        dec.wr_en   = rd_v && (dec.rd != 5'd0);
        dec.illegal = ill;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, flush,
// load-use hazard stall and a one-entry output register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_valid,
    output logic            out_rs2_valid,
    output logic            out_wr_en,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_alu_op,
    output logic            out_is_branch,
    output logic            out_is_jal,
    output logic            out_is_jalr,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_lui,
    output logic            out_is_auipc,
    output logic            out_illegal
);

    dec_t            dec;
    dec_t            q;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] q_imm;
    logic [PC_W-1:0] q_pc;
    logic            q_valid;
    logic            hazard;
    logic            accept;

    decode_comb #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_comb (
        .instr (in_instr),
        .dec   (dec),
        .imm   (dec_imm)
    );

    // A held load whose rd feeds the incoming instruction blocks it for one cycle
    assign hazard = q_valid && q.is_load && (q.rd != 5'd0)
                 && ((dec.rs1_valid && dec.rs1 == q.rd)
                  || (dec.rs2_valid && dec.rs2 == q.rd));

    assign in_ready = !flush && !hazard && (!q_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Output register: flush kills, accept loads, drain empties, stall holds
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
            q_imm   <= '0;
            q_pc    <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (accept) begin
            q_valid <= 1'b1;
            q       <= dec;
            q_imm   <= dec_imm;
            q_pc    <= in_pc;
        end else if (out_ready) begin
            q_valid <= 1'b0;
        end
    end

    assign out_valid     = q_valid;
    assign out_pc        = q_pc;
    assign out_rs1       = q.rs1;
    assign out_rs2       = q.rs2;
    assign out_rd        = q.rd;
    assign out_rs1_valid = q.rs1_valid;
    assign out_rs2_valid = q.rs2_valid;
    assign out_wr_en     = q.wr_en;
    assign out_imm       = q_imm;
    assign out_funct3    = q.funct3;
    assign out_alu_op    = q.alu_op;
    assign out_is_branch = q.is_branch;
    assign out_is_jal    = q.is_jal;
    assign out_is_jalr   = q.is_jalr;
    assign out_is_load   = q.is_load;
    assign out_is_store  = q.is_store;
    assign out_is_lui    = q.is_lui;
    assign out_is_auipc  = q.is_auipc;
    assign out_illegal   = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage (XLEN=32, M enabled)
// against an instruction-level reference decoder.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        rs1v, rs2v, wr;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [4:0]  alu;
        logic        br, jal, jalr, ld, st, lui, auipc, ill;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rs1_valid, out_rs2_valid, out_wr_en;
    logic [31:0] out_imm;
    logic [2:0]  out_funct3;
    logic [4:0]  out_alu_op;
    logic        out_is_branch, out_is_jal, out_is_jalr, out_is_load;
    logic        out_is_store, out_is_lui, out_is_auipc, out_illegal;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sbq[$];
    bit   m_valid = 0;
    exp_t m_exp;
    logic [31:0] pc_ctr = 32'h1000;

    localparam alu_op_t BASE_OPS [8] = '{ALU_ADD, ALU_SLL, ALU_SLT,
        ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam alu_op_t M_OPS [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU,
        ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23,
        7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h3B, 7'h1B};

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .PC_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_rs1_valid(out_rs1_valid),
        .out_rs2_valid(out_rs2_valid), .out_wr_en(out_wr_en),
        .out_imm(out_imm), .out_funct3(out_funct3),
        .out_alu_op(out_alu_op), .out_is_branch(out_is_branch),
        .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_lui(out_is_lui), .out_is_auipc(out_is_auipc),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    function automatic logic [97:0] pack(input exp_t e);
        return {e.pc, e.rs1, e.rs2, e.rd, e.rs1v, e.rs2v, e.wr,
                e.imm, e.f3, e.alu, e.br, e.jal, e.jalr, e.ld,
                e.st, e.lui, e.auipc, e.ill};
    endfunction

    // Reference decoder written from the ISA encoding rules
    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit rdv, ok;
        int v;
        e = '{default: 0};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.f3  = f3;
        e.alu = ALU_ADD;
        ok = 1;
        rdv = 0;
        case (op)
            7'h33: begin
                rdv = 1; e.rs1v = 1; e.rs2v = 1;
                if (f7 == 0) e.alu = BASE_OPS[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
                else if (f7 == 7'h01) e.alu = M_OPS[f3];
                else ok = 0;
            end
            7'h13: begin
                rdv = 1; e.rs1v = 1;
                v = int'(ins[31:20]);
                e.imm = sx(v, 12);
                if (f3 == 1) begin
                    e.alu = ALU_SLL; ok = (f7 == 0);
                end else if (f3 == 5) begin
                    if (f7 == 0) e.alu = ALU_SRL;
                    else if (f7 == 7'h20) e.alu = ALU_SRA;
                    else ok = 0;
                end else e.alu = BASE_OPS[f3];
            end
            7'h03: begin
                rdv = 1; e.rs1v = 1; e.ld = 1;
                v = int'(ins[31:20]);
                e.imm = sx(v, 12);
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin
                e.rs1v = 1; e.rs2v = 1; e.st = 1;
                v = int'({ins[31:25], ins[11:7]});
                e.imm = sx(v, 12);
                ok = (f3 < 3);
            end
            7'h63: begin
                e.rs1v = 1; e.rs2v = 1; e.br = 1; e.alu = ALU_SUB;
                v = int'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
                e.imm = sx(v, 13);
                ok = (f3 != 2 && f3 != 3);
            end
            7'h6F: begin
                rdv = 1; e.jal = 1;
                v = int'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
                e.imm = sx(v, 21);
            end
            7'h67: begin
                rdv = 1; e.rs1v = 1; e.jalr = 1;
                v = int'(ins[31:20]);
                e.imm = sx(v, 12);
                ok = (f3 == 0);
            end
            7'h37: begin
                rdv = 1; e.lui = 1; e.alu = ALU_PASSB;
                e.imm = ins & 32'hFFFF_F000;
            end
            7'h17: begin
                rdv = 1; e.auipc = 1;
                e.imm = ins & 32'hFFFF_F000;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            rdv = 0; e.rs1v = 0; e.rs2v = 0; e.imm = 0;
            e.alu = ALU_ADD;
            {e.br, e.jal, e.jalr, e.ld, e.st, e.lui, e.auipc} = '0;
        end
        e.wr  = rdv && (e.rd != 0);
        e.ill = !ok;
        return e;
    endfunction

    function automatic exp_t cur();
        exp_t a;
        a = '{default: 0};
        a.pc = out_pc; a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd;
        a.rs1v = out_rs1_valid; a.rs2v = out_rs2_valid; a.wr = out_wr_en;
        a.imm = out_imm; a.f3 = out_funct3; a.alu = out_alu_op;
        a.br = out_is_branch; a.jal = out_is_jal; a.jalr = out_is_jalr;
        a.ld = out_is_load; a.st = out_is_store; a.lui = out_is_lui;
        a.auipc = out_is_auipc; a.ill = out_illegal;
        return a;
    endfunction

    task automatic chk(input bit ok, input string nm,
                       input logic [97:0] act, input logic [97:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // One cycle of stimulus; the handshake model predicts in_ready/accept
    task automatic step(input bit v, input logic [31:0] ins,
                        input bit ordy, input bit fl, input bit r,
                        output bit acc);
        exp_t d;
        bit hz, rdy;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_instr = ins; in_pc = pc_ctr;
        out_ready = ordy; flush = fl;
        #2;
        d = ref_dec(ins);
        d.pc = pc_ctr;
        hz = m_valid && m_exp.ld && m_exp.rd != 0
          && ((d.rs1v && d.rs1 == m_exp.rd)
           || (d.rs2v && d.rs2 == m_exp.rd));
        rdy = !fl && !hz && (!m_valid || ordy);
        acc = 0;
        if (r) begin
            m_valid = 0;
        end else begin
            chk(in_ready === rdy, "in_ready", 98'(in_ready), 98'(rdy));
            acc = v && rdy;
            if (fl) m_valid = 0;
            else if (acc) begin
                d.tag = cyc;
                m_valid = 1; m_exp = d;
                sbq.push_back(d);
            end else if (ordy) m_valid = 0;
        end
        if (acc) pc_ctr = pc_ctr + 4;
    endtask

    task automatic send(input logic [31:0] ins);
        bit acc;
        int n;
        n = 0;
        acc = 0;
        while (!acc && n < 20) begin
            step(1, ins, 1, 0, 0, acc);
            n++;
        end
        chk(acc, "send_accept", 98'(acc), 98'(1));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] op, f7;
        int k;
        if ($urandom_range(0, 15) == 0) return $urandom;
        k = $urandom_range(0, 11);
        op = (k < 11) ? OPS[k] : 7'($urandom);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    // Monitor: pops on transfer, drops on flush/reset, checks stall stability
    initial begin : monitor
        exp_t e;
        bit exp_v;
        bit prev_stall;
        logic [97:0] prev_snap;
        prev_stall = 0;
        prev_snap = '0;
        forever begin
            @(negedge clk);
            exp_v = (sbq.size() > 0) && (sbq[0].tag < cyc);
            chk(out_valid === exp_v, "out_valid",
                98'(out_valid), 98'(exp_v));
            if (out_valid && exp_v) begin
                if (out_ready) begin
                    e = sbq.pop_front();
                    chk(pack(cur()) === pack(e), "bundle",
                        pack(cur()), pack(e));
                end else if (flush || rst) begin
                    e = sbq.pop_front();
                end
            end
            if (prev_stall)
                chk(pack(cur()) === prev_snap, "stall_hold",
                    pack(cur()), prev_snap);
            prev_stall = out_valid && !out_ready && !flush && !rst;
            prev_snap = pack(cur());
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit acc;
        repeat (3) @(posedge clk);
        #3;
        chk(out_valid === 1'b0, "reset_valid", 98'(out_valid), 98'(0));
        chk(pack(cur()) === '0, "reset_data", pack(cur()), '0);
        step(0, 32'h0, 1, 0, 0, acc);

        send(32'h00500093);
        send(32'hFE000EE3);
        send(32'h0000A103);
        send(32'h001101B3);
        send(32'h00100113);
        repeat (3) step(1, 32'h00208193, 0, 0, 0, acc);
        send(32'h00208193);
        send(32'h022082B3);
        send(32'h00000000);
        send(32'h00300213);
        step(1, 32'h00400293, 0, 0, 0, acc);
        step(1, 32'h00500313, 0, 1, 0, acc);
        send(32'h00600393);
        step(0, 32'h0, 1, 0, 0, acc);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, 0, acc);
        repeat (3) step(0, 32'h0, 1, 0, 0, acc);

        send(32'h00700413);
        step(0, 32'h0, 0, 0, 0, acc);
        step(0, 32'h0, 0, 0, 1, acc);
        step(0, 32'h0, 1, 0, 0, acc);
        chk(out_valid === 1'b0, "midstall_rst_valid",
            98'(out_valid), 98'(0));
        chk(pack(cur()) === '0, "midstall_rst_data", pack(cur()), '0);
        repeat (2) step(0, 32'h0, 1, 0, 0, acc);
        @(negedge clk);
        #1;
        chk(sbq.size() == 0, "queue_empty", 98'(sbq.size()), 98'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage; sits between fetch and execute.
- Accepts {pc, instr} over a valid/ready handshake and emits a registered decoded bundle: fields, immediate, type flags, ALU op, branch/jump/load/store flags and an illegal-instruction flag.
- Generalises the combinational decoder:
  - XLEN-parametrised immediates;
  - optional M-extension decode;
  - a one-entry output register with back-pressure;
  - flush;
  - load-use hazard stall.

Parameters:
- XLEN, 32, datapath and immediate width; only 32 or 64 are legal; immediates sign-extend to XLEN.
- ENABLE_M, 1, when 1, decode MUL/DIV/REM (funct7=0000001, op 0110011); when 0, these raise illegal.
- PC_W, 32, program-counter width carried through.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents {in_pc, in_instr}
- in_ready  output  1  stage accepts this cycle
- in_pc  input  PC_W  pc of the instruction
- in_instr  input  32  raw instruction
- flush  input  1  kill held and incoming instruction (branch redirect)
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts the bundle
- out_pc  output  PC_W  registered pc
- out_rs1 / out_rs2 / out_rd  output  5 each  register indices
- out_rs1_valid / out_rs2_valid / out_wr_en  output  1 each  operand use; write enable (rd_valid && rd!=0)
- out_imm  output  XLEN  sign-extended immediate (0 for R-type)
- out_funct3  output  3  funct3
- out_alu_op  output  5  alu_op_t encoding
- out_is_branch / out_is_jal / out_is_jalr / out_is_load / out_is_store / out_is_lui / out_is_auipc  output  1 each  class flags
- out_illegal  output  1  unsupported or malformed encoding (instr[1:0]!=11, unknown opcode/funct)

Behaviour:
- Reset:
  - out_valid=0 and every out_* data field=0.
  - in_ready is combinational and equals 1 the cycle after reset releases.
- Decode is combinational on in_instr and is captured into the output register on accept.
- Latency is exactly 1 cycle from accept to out_valid.
- hazard = out_valid && out_is_load && out_rd!=0 && ((dec_rs1_valid && dec_rs1==out_rd) || (dec_rs2_valid && dec_rs2==out_rd)).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready: register loads the decoded bundle; out_valid<=1.
- Drain without accept (out_valid && out_ready && !accept): out_valid<=0.
- Stall (out_valid && !out_ready): all out_* hold stable. The bundle must not change while out_valid && !out_ready.
- Load-use: when the held load transfers while hazard=1, the next cycle presents a bubble (out_valid=0). The dependent instruction is accepted one cycle later. This yields exactly one bubble.
- Flush: priority over everything. Next cycle out_valid=0; the incoming instruction is dropped (in_ready=0 that cycle).
- Simultaneous flush && out_ready: the held bundle counts as consumed only if execute sampled it; the stage clears it regardless.
- An illegal instruction still propagates with out_illegal=1; out_wr_en=0, all class flags=0, and alu_op=ALU_ADD.
- Reset mid-stall: out_valid=0 on the next edge, and the held bundle is discarded.
- ALU op selection:
  - R/I-type from {funct7[5], funct3}. funct7[5] is used for SUB/SRA/SRAI only; for I-type, bit 30 is ignored except for shifts.
  - Branches use ALU_SUB.
  - Loads/stores/JAL/JALR/AUIPC use ALU_ADD.
  - LUI uses ALU_PASSB.
- Immediates are formed per I/S/B/U/J type and sign-extended from instr[31] to XLEN.
- XLEN=64: the W-opcodes (0011011, 0111011) decode to I/R-type ALU ops with a W variant. For XLEN=32 those opcodes are illegal.

Decomposition:
- Package decode_pkg holds:
  - alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, plus W variants);
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_32, OP_IMM_32);
  - a packed decoded-bundle struct.
- One sub-module, decode_comb: purely combinational field/immediate/flag/illegal decode, parametrised by XLEN and ENABLE_M.
- decode_stage owns the handshake, the hazard check and the register.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with out_ready=1 → next cycle out_valid=1, rd=1, imm=5, wr_en=1, alu_op=ADD, illegal=0.
- beq x0,x0,-4 (0xFE000EE3) → out_is_branch=1, imm=0xFFFFFFFC, wr_en=0, rs1_valid=rs2_valid=1, alu_op=SUB.
- lw x2,0(x1) (0x0000A103), then add x3,x2,x1 (0x001101B3), back-to-back, out_ready=1 → lw out, then 1 bubble (out_valid=0), then add out. in_ready=0 exactly one cycle.
- out_ready=0 for 3 cycles with valid held → in_ready=0 and all out_* stable for 3 cycles. When out_ready rises, the next instruction follows with no loss.
- mul x5,x1,x2 (0x022082B3) → ENABLE_M=1: alu_op=MUL, illegal=0. ENABLE_M=0: illegal=1, wr_en=0. Instr 0x00000000 → illegal=1.
- flush asserted while a bundle is held and in_valid=1 → next cycle out_valid=0; the incoming instruction does not appear. The instruction after flush decodes normally.
